// File: rtl/digota_drv_array.sv
// Multi-channel digital OTA output-stage driver.
//
// Each channel decodes its synchronised comparator bits (inp_b, inm_b) and the
// shared output enable into one of five drive states. It then drives the four
// output-stage gates from registers.
//
// Any change between two conducting states passes through OFF first. The OFF
// gap (dead time) lasts max(dead_cyc,1) clock cycles.
//
// Ports:
//   clk, rst_n      block clock, asynchronous active-low reset
//   oe              global output enable (asynchronous, synchronised here)
//   cm_en           enables the common-mode states (quasi-static, not synchronised)
//   dead_cyc        dead-time length in cycles, sampled on dead-time entry
//   inp_b, inm_b    per-channel comparator bits (asynchronous)
//   opmos, cmpmos   PMOS gates, 0 = on
//   onmos, cmnmos   NMOS gates, 1 = on
//   busy            per-channel dead-time indicator
module digota_drv_array #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             oe,
  input  logic             cm_en,
  input  logic [CNT_W-1:0] dead_cyc,
  input  logic [NCH-1:0]   inp_b,
  input  logic [NCH-1:0]   inm_b,
  output logic [NCH-1:0]   opmos,
  output logic [NCH-1:0]   onmos,
  output logic [NCH-1:0]   cmpmos,
  output logic [NCH-1:0]   cmnmos,
  output logic [NCH-1:0]   busy
);

  typedef enum logic [2:0] {DrvOff, DrvUp, DrvDn, DrvCmp, DrvCmn} drv_e;
  typedef enum logic [0:0] {StActive, StDead} st_e;

  // Gate tuple {opmos, onmos, cmpmos, cmnmos}
  localparam logic [3:0] GateOff = 4'b1010;

  function automatic logic [3:0] gate_of(input drv_e d);
    logic [3:0] g;
    g = GateOff;
    unique case (d)
      DrvUp:   g = 4'b0010;
      DrvDn:   g = 4'b1110;
      DrvCmp:  g = 4'b1000;
      DrvCmn:  g = 4'b1011;
      default: g = GateOff;
    endcase
    return g;
  endfunction

  // Synchroniser chains: index 0 is the capture flop, index SYNC_STAGES-1 is the
  // flop that the decode uses.
  logic [SYNC_STAGES-1:0]          oe_sync;
  logic [SYNC_STAGES-1:0][NCH-1:0] p_sync;
  logic [SYNC_STAGES-1:0][NCH-1:0] m_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_sync <= '0;
      p_sync  <= '0;
      m_sync  <= '0;
    end else begin
      oe_sync <= {oe_sync[SYNC_STAGES-2:0], oe};
      p_sync  <= {p_sync[SYNC_STAGES-2:0], inp_b};
      m_sync  <= {m_sync[SYNC_STAGES-2:0], inm_b};
    end
  end

  logic s_oe;
  assign s_oe = oe_sync[SYNC_STAGES-1];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic             s_p, s_m;
    drv_e             tgt;
    drv_e             cur_q, cur_d;
    st_e              st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gate_q;
    logic             busy_q;

    assign s_p = p_sync[SYNC_STAGES-1][c];
    assign s_m = m_sync[SYNC_STAGES-1][c];

    always_comb begin
      tgt = DrvOff;
      if (s_oe) begin
        unique case ({s_p, s_m})
          2'b01:   tgt = DrvUp;
          2'b10:   tgt = DrvDn;
          2'b11:   tgt = cm_en ? DrvCmp : DrvOff;
          default: tgt = cm_en ? DrvCmn : DrvOff;
        endcase
      end
    end

    always_comb begin
      st_d  = st_q;
      cur_d = cur_q;
      cnt_d = cnt_q;
      unique case (st_q)
        StActive: begin
          if (tgt != cur_q) begin
            if (cur_q == DrvOff || tgt == DrvOff) begin
              cur_d = tgt;
            end else begin
              // Conducting-to-conducting change: break first, make later.
              cur_d = DrvOff;
              st_d  = StDead;
              cnt_d = (dead_cyc == '0) ? CNT_W'(1) : dead_cyc;
            end
          end
        end
        StDead: begin
          // The counter is not restarted by target changes; the latest target wins at expiry.
          if (cnt_q <= CNT_W'(1)) begin
            cur_d = tgt;
            st_d  = StActive;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          st_d  = StActive;
          cur_d = DrvOff;
          cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q   <= StActive;
        cur_q  <= DrvOff;
        cnt_q  <= '0;
        gate_q <= GateOff;
        busy_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        cur_q  <= cur_d;
        cnt_q  <= cnt_d;
        gate_q <= gate_of(cur_d);
        busy_q <= (st_d == StDead);
      end
    end

    assign opmos[c]  = gate_q[3];
    assign onmos[c]  = gate_q[2];
    assign cmpmos[c] = gate_q[1];
    assign cmnmos[c] = gate_q[0];
    assign busy[c]   = busy_q;
  end

endmodule

// File: tb/tb_digota_drv_array.sv
// Directed self-checking bench for digota_drv_array (NCH=4, SYNC_STAGES=2).
module tb_digota_drv_array;
  localparam int NCH = 4;
  localparam int CW  = 4;

  localparam logic [3:0] T_OFF = 4'b1010;
  localparam logic [3:0] T_UP  = 4'b0010;
  localparam logic [3:0] T_DN  = 4'b1110;
  localparam logic [3:0] T_CMP = 4'b1000;
  localparam logic [3:0] T_CMN = 4'b1011;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           oe = 1'b0;
  logic           cm_en = 1'b0;
  logic [CW-1:0]  dead_cyc = 4'd3;
  logic [NCH-1:0] inp_b = '0;
  logic [NCH-1:0] inm_b = '0;
  logic [NCH-1:0] opmos, onmos, cmpmos, cmnmos, busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_viol = 0;

  digota_drv_array #(.NCH(NCH), .SYNC_STAGES(2), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .oe(oe), .cm_en(cm_en), .dead_cyc(dead_cyc),
    .inp_b(inp_b), .inm_b(inm_b), .opmos(opmos), .onmos(onmos),
    .cmpmos(cmpmos), .cmnmos(cmnmos), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ch_out(input int c);
    return {opmos[c], onmos[c], cmpmos[c], cmnmos[c]};
  endfunction

  // Shoot-through / multiple-gate-on monitor.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      int on_cnt;
      on_cnt = int'(!opmos[c]) + int'(onmos[c]) + int'(!cmpmos[c]) + int'(cmnmos[c]);
      if ((!opmos[c] && onmos[c]) || on_cnt > 1) n_viol++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs must already be changed; the capture edge is the next tick.
  task automatic check_bridge(input string tag, input int c, input logic [3:0] from,
                              input logic [3:0] to, input int dc);
    for (int i = 0; i <= 2 + dc; i++) begin
      logic [3:0] e;
      logic       eb;
      tick();
      e  = (i < 2) ? from : ((i < 2 + dc) ? T_OFF : to);
      eb = (i >= 2) && (i < 2 + dc);
      check_eq($sformatf("%s_out_%0d", tag, i), 32'(ch_out(c)), 32'(e));
      check_eq($sformatf("%s_busy_%0d", tag, i), 32'(busy[c]), 32'(eb));
    end
  endtask

  initial begin
    // 1: reset with random inputs
    inp_b = NCH'($urandom);
    inm_b = NCH'($urandom);
    oe    = 1'($urandom);
    cm_en = 1'($urandom);
    repeat (3) tick();
    check_eq("rst_opmos", 32'(opmos), 32'hF);
    check_eq("rst_onmos", 32'(onmos), 32'h0);
    check_eq("rst_cmpmos", 32'(cmpmos), 32'hF);
    check_eq("rst_cmnmos", 32'(cmnmos), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    oe = 1'b0; cm_en = 1'b0; inp_b = 4'b1110; inm_b = 4'b1111;
    rst_n = 1'b1;
    repeat (4) tick();
    check_eq("oe0_opmos", 32'(opmos), 32'hF);
    check_eq("oe0_onmos", 32'(onmos), 32'h0);

    // 2: enable, ch0 UP after two cycles
    oe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("up0_out_%0d", i), 32'(ch_out(0)), 32'((i < 2) ? T_OFF : T_UP));
      check_eq($sformatf("up0_busy_%0d", i), 32'(busy[0]), 32'h0);
    end

    // 3: ch0 UP -> DN bridged
    inp_b[0] = 1'b1; inm_b[0] = 1'b0;
    check_bridge("updn0", 0, T_UP, T_DN, 3);

    // 4: common-mode gating on ch1
    check_eq("cm_off1", 32'(ch_out(1)), 32'(T_OFF));
    cm_en = 1'b1;
    tick();
    check_eq("cmp1", 32'(ch_out(1)), 32'(T_CMP));
    inp_b[1] = 1'b0; inm_b[1] = 1'b0;
    check_bridge("cmpcmn1", 1, T_CMP, T_CMN, 3);

    // 5: target toggles and dead_cyc change during ch2 dead time
    inp_b[2] = 1'b0; inm_b[2] = 1'b1;
    check_bridge("cmpup2", 2, T_CMP, T_UP, 3);
    inp_b[2] = 1'b1; inm_b[2] = 1'b0;
    repeat (3) tick();
    check_eq("tog2_entry", 32'({busy[2], ch_out(2)}), 32'({1'b1, T_OFF}));
    dead_cyc = 4'd7;
    inp_b[2] = 1'b0; inm_b[2] = 1'b1;
    tick();
    check_eq("tog2_d1", 32'({busy[2], ch_out(2)}), 32'({1'b1, T_OFF}));
    tick();
    check_eq("tog2_d2", 32'({busy[2], ch_out(2)}), 32'({1'b1, T_OFF}));
    tick();
    check_eq("tog2_exp", 32'({busy[2], ch_out(2)}), 32'({1'b0, T_UP}));
    tick();
    check_eq("tog2_hold", 32'({busy[2], ch_out(2)}), 32'({1'b0, T_UP}));
    dead_cyc = 4'd3;

    // 6: reset in the middle of ch3 dead time
    inp_b[3] = 1'b0;
    repeat (4) tick();
    check_eq("pre_rst_busy3", 32'(busy[3]), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_opmos", 32'(opmos), 32'hF);
    check_eq("mid_rst_onmos", 32'(onmos), 32'h0);
    check_eq("mid_rst_cmpmos", 32'(cmpmos), 32'hF);
    check_eq("mid_rst_cmnmos", 32'(cmnmos), 32'h0);
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check_eq("post_rst_opmos", 32'(opmos), 32'b0011);
    check_eq("post_rst_onmos", 32'(onmos), 32'b0001);
    check_eq("post_rst_cmpmos", 32'(cmpmos), 32'hF);
    check_eq("post_rst_cmnmos", 32'(cmnmos), 32'b0010);
    check_eq("post_rst_busy", 32'(busy), 32'h0);

    // dead_cyc = 0 behaves as a single cycle
    dead_cyc = 4'd0;
    inp_b[0] = 1'b0; inm_b[0] = 1'b1;
    check_bridge("dc0", 0, T_DN, T_UP, 1);

    tick();
    check_eq("no_overlap", 32'(n_viol), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
